// File: rtl/llc_set_engine.sv
// llc_set_engine: N-way, S-set LLC tag/MESI/tree-PLRU engine with request FSM.
// Serves local reads/writes and snooped bus ops, reporting victims and bus/L1 codes.
module llc_set_engine #(
  parameter int WAYS = 16,
  parameter int SETS = 64,
  parameter int TAG_BITS = 12,
  localparam int SET_BITS = $clog2(SETS),
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [TAG_BITS-1:0] req_tag,
  input  logic [1:0]          bus_snoop_in,
  output logic [2:0]          bus_op,
  output logic [1:0]          snoop_result,
  output logic [2:0]          l1_msg,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [WAY_BITS-1:0] resp_way,
  output logic                evict_valid,
  output logic [TAG_BITS-1:0] evict_tag,
  output logic                evict_dirty
);
  typedef enum logic [2:0] {IDLE, LOOKUP, UPDATE, EVICT_WB, CLEAR} state_t;
  localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
  localparam logic [2:0] BUS_READ = 3'd0, BUS_WRITE = 3'd1, BUS_INV = 3'd2, BUS_RWIM = 3'd3, BUS_NONE = 3'd4;
  localparam logic [1:0] SR_NOHIT = 2'd0, SR_HIT = 2'd1, SR_HITM = 2'd2, SR_NORES = 2'd3;
  localparam logic [2:0] L1_GET = 3'd0, L1_SEND = 3'd1, L1_INV = 3'd2, L1_EVICT = 3'd3, L1_NONE = 3'd4;
  state_t state, state_nx;
  logic [TAG_BITS-1:0] tags [SETS][WAYS];
  logic [1:0] mesi [SETS][WAYS];
  logic [WAYS-2:0] plru [SETS];
  logic [2:0] op;
  logic [SET_BITS-1:0] set_r;
  logic [TAG_BITS-1:0] tag_r;
  logic [1:0] snoop_r, cur, new_st;
  logic clr_done, loc, hit, has_inv, evict, dirty, snp_wb, inv_l1, upd;
  logic [WAY_BITS-1:0] hit_way, inv_way, plru_way, fill_way, acc_way;
  logic [WAYS-2:0] plru_nx;
  int node;
  // Lookup is purely combinational on the held set, so LOOKUP and UPDATE see the same result.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (mesi[set_r][i] != MESI_I && tags[set_r][i] == tag_r) begin
        hit = 1'b1;
        hit_way = WAY_BITS'(i);
      end
      if (mesi[set_r][i] == MESI_I) begin
        has_inv = 1'b1;
        inv_way = WAY_BITS'(i);
      end
    end
    node = 0;
    plru_way = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      plru_way[WAY_BITS-1-l] = plru[set_r][node];
      node = 2 * node + 1 + int'(plru[set_r][node]);
    end
    fill_way = has_inv ? inv_way : plru_way;
    acc_way = hit ? hit_way : fill_way;
    plru_nx = plru[set_r];
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      plru_nx[node] = ~acc_way[WAY_BITS-1-l];
      node = 2 * node + 1 + int'(acc_way[WAY_BITS-1-l]);
    end
    loc = op == 3'd0 || op == 3'd1;
    cur = hit ? mesi[set_r][hit_way] : MESI_I;
    evict = loc && !hit && !has_inv;
    dirty = evict && mesi[set_r][fill_way] == MESI_M;
    snp_wb = (op == 3'd2 || op == 3'd4) && cur == MESI_M;
    inv_l1 = (op == 3'd4 && hit) || (op == 3'd5 && cur == MESI_S);
    new_st = op == 3'd0 ? (hit ? cur : (snoop_r == SR_NOHIT ? MESI_E : MESI_S)) :
             op == 3'd1 ? MESI_M :
             op == 3'd2 ? (hit ? MESI_S : MESI_I) :
             op == 3'd4 ? MESI_I :
             op == 3'd5 ? (cur == MESI_S ? MESI_I : cur) : cur;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (req_valid ? (req_op == 3'd6 ? CLEAR : LOOKUP) : IDLE) :
               state == LOOKUP ? UPDATE :
               state == UPDATE ? (dirty ? EVICT_WB : IDLE) :
               state == CLEAR ? (set_r == SET_BITS'(SETS - 1) ? IDLE : CLEAR) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= 3'd0;
      set_r <= '0;
      tag_r <= '0;
      snoop_r <= 2'd0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= state == CLEAR && set_r == SET_BITS'(SETS - 1);
      if (state == IDLE && req_valid) begin
        op <= req_op;
        set_r <= req_op == 3'd6 ? '0 : req_set;
        tag_r <= req_tag;
      end
      if (state == LOOKUP) snoop_r <= bus_snoop_in;
      if (state == CLEAR) set_r <= set_r + 1'b1;
    end
  // Snoop misses must not touch the arrays: hit_way is 0 there and may name a live line.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tags[s][w] <= '0;
          mesi[s][w] <= MESI_I;
        end
      end
    end else if (state == UPDATE && (loc || hit)) begin
      mesi[set_r][acc_way] <= new_st;
      if (loc) begin
        tags[set_r][acc_way] <= tag_r;
        plru[set_r] <= plru_nx;
      end
    end else if (state == CLEAR) begin
      plru[set_r] <= '0;
      for (int w = 0; w < WAYS; w++) mesi[set_r][w] <= MESI_I;
    end
  always_comb begin
    upd = state == UPDATE;
    req_ready = state == IDLE;
    bus_op = state == EVICT_WB ? (op == 3'd1 ? BUS_RWIM : BUS_READ) :
             state != LOOKUP ? BUS_NONE :
             loc ? (hit ? (op == 3'd1 && cur == MESI_S ? BUS_INV : BUS_NONE) :
                    dirty ? BUS_WRITE : op == 3'd1 ? BUS_RWIM : BUS_READ) :
             snp_wb ? BUS_WRITE : BUS_NONE;
    l1_msg = state == LOOKUP && snp_wb ? L1_GET :
             !upd ? L1_NONE :
             loc ? (evict ? L1_EVICT : op == 3'd0 ? L1_SEND : L1_NONE) :
             inv_l1 ? L1_INV : L1_NONE;
    snoop_result = !upd || loc ? SR_NORES :
                   snp_wb ? SR_HITM :
                   op == 3'd2 || op == 3'd4 ? (hit ? SR_HIT : SR_NOHIT) :
                   op == 3'd5 && cur == MESI_S ? SR_HIT : SR_NOHIT;
    resp_valid = upd || clr_done;
    resp_hit = upd && hit;
    resp_way = upd && (loc || hit) ? acc_way : '0;
    evict_valid = upd && evict;
    evict_tag = upd && evict ? tags[set_r][fill_way] : '0;
    evict_dirty = upd && dirty;
  end
endmodule

// File: tb/tb_llc_set_engine.sv
// tb_llc_set_engine: directed table, corner sequences and randomized model checks of llc_set_engine.
module tb_llc_set_engine;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_ready;
  logic [2:0] req_op = 3'd0;
  logic [1:0] req_set = 2'd0, bus_snoop_in = 2'd0;
  logic [7:0] req_tag = 8'd0;
  logic [2:0] bus_op, l1_msg;
  logic [1:0] snoop_result, resp_way;
  logic resp_valid, resp_hit, evict_valid, evict_dirty;
  logic [7:0] evict_tag;
  int checks = 0, failures = 0;
  typedef struct { int op, set, tag, snp, bus1, l1a, sr, l1, hit, way, ev, etag, ed, bus3; } vec_t;
  typedef struct { int bus1, l1a, sr, l1, hit, way, ev, etag, ed, bus3, bus2, rv1, rv2, rv3, rdy3; } obs_t;
  int m_tag [4][4];
  int m_st [4][4];
  int m_plru [4][3];

  llc_set_engine #(.WAYS(4), .SETS(4), .TAG_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_set(req_set), .req_tag(req_tag), .bus_snoop_in(bus_snoop_in), .bus_op(bus_op),
    .snoop_result(snoop_result), .l1_msg(l1_msg), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_way(resp_way), .evict_valid(evict_valid), .evict_tag(evict_tag), .evict_dirty(evict_dirty)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_tag[s][w] = 0;
        m_st[s][w] = 0;
      end
      for (int n = 0; n < 3; n++) m_plru[s][n] = 0;
    end
  endtask

  function automatic int victim(input int s);
    int n = 0, w = 0, b;
    for (int l = 0; l < 2; l++) begin
      b = m_plru[s][n];
      w = w * 2 + b;
      n = 2 * n + 1 + b;
    end
    return w;
  endfunction

  task automatic touch(input int s, input int w);
    int n = 0, b;
    for (int l = 0; l < 2; l++) begin
      b = (w >> (1 - l)) & 1;
      m_plru[s][n] = 1 - b;
      n = 2 * n + 1 + b;
    end
  endtask

  // Reference behaviour: returns expected outputs and advances the model state.
  task automatic model_step(input vec_t r, output vec_t e);
    int s = r.set, hw = -1, cur = 0, fw, vs, fb;
    e = r;
    for (int w = 3; w >= 0; w--) if (m_st[s][w] != 0 && m_tag[s][w] == r.tag) hw = w;
    if (hw >= 0) cur = m_st[s][hw];
    e.bus1 = 4; e.l1a = 4; e.sr = 3; e.l1 = 4; e.hit = hw >= 0; e.way = hw >= 0 ? hw : 0;
    e.ev = 0; e.etag = 0; e.ed = 0; e.bus3 = 4;
    if (r.op <= 1) begin
      if (hw >= 0) begin
        if (r.op == 0) e.l1 = 1;
        else begin
          if (cur == 1) e.bus1 = 2;
          m_st[s][hw] = 3;
        end
        touch(s, hw);
      end else begin
        fw = -1;
        for (int w = 3; w >= 0; w--) if (m_st[s][w] == 0) fw = w;
        if (fw < 0) fw = victim(s);
        vs = m_st[s][fw];
        e.way = fw;
        if (vs != 0) begin
          e.ev = 1;
          e.etag = m_tag[s][fw];
          e.ed = vs == 3;
        end
        e.l1 = e.ev ? 3 : (r.op == 0 ? 1 : 4);
        fb = r.op == 0 ? 0 : 3;
        if (e.ed) begin
          e.bus1 = 1;
          e.bus3 = fb;
        end else e.bus1 = fb;
        m_st[s][fw] = r.op == 0 ? (r.snp == 0 ? 2 : 1) : 3;
        m_tag[s][fw] = r.tag;
        touch(s, fw);
      end
    end else if (r.op == 2 || r.op == 4) begin
      e.sr = cur == 3 ? 2 : (hw >= 0 ? 1 : 0);
      if (cur == 3) begin
        e.bus1 = 1;
        e.l1a = 0;
      end
      if (hw >= 0) begin
        if (r.op == 4) e.l1 = 2;
        m_st[s][hw] = r.op == 2 ? 1 : 0;
      end
    end else if (r.op == 5) begin
      e.sr = cur == 1 ? 1 : 0;
      if (cur == 1) begin
        e.l1 = 2;
        m_st[s][hw] = 0;
      end
    end else e.sr = 0;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_req(input vec_t r, output obs_t o);
    wait_ready();
    req_valid = 1'b1;
    req_op = 3'(r.op);
    req_set = 2'(r.set);
    req_tag = 8'(r.tag);
    bus_snoop_in = 2'(r.snp);
    @(negedge clk);
    req_valid = 1'b0;
    o.bus1 = int'(bus_op); o.l1a = int'(l1_msg); o.rv1 = int'(resp_valid);
    @(negedge clk);
    o.sr = int'(snoop_result); o.l1 = int'(l1_msg); o.hit = int'(resp_hit); o.way = int'(resp_way);
    o.ev = int'(evict_valid); o.etag = int'(evict_tag); o.ed = int'(evict_dirty);
    o.bus2 = int'(bus_op); o.rv2 = int'(resp_valid);
    @(negedge clk);
    o.bus3 = int'(bus_op); o.rv3 = int'(resp_valid); o.rdy3 = int'(req_ready);
    if (!req_ready) @(negedge clk);
  endtask

  task automatic check_obs(input string nm, input obs_t o, input vec_t e);
    chk({nm, " bus_op@lookup"}, o.bus1, e.bus1);
    chk({nm, " l1_msg@lookup"}, o.l1a, e.l1a);
    chk({nm, " snoop_result"}, o.sr, e.sr);
    chk({nm, " l1_msg@update"}, o.l1, e.l1);
    chk({nm, " resp_hit"}, o.hit, e.hit);
    chk({nm, " resp_way"}, o.way, e.way);
    chk({nm, " evict_valid"}, o.ev, e.ev);
    chk({nm, " evict_tag"}, o.etag, e.etag);
    chk({nm, " evict_dirty"}, o.ed, e.ed);
    chk({nm, " bus_op@evict_wb"}, o.bus3, e.bus3);
    chk({nm, " bus_op@update"}, o.bus2, 4);
    chk({nm, " resp_valid@lookup"}, o.rv1, 0);
    chk({nm, " resp_valid@update"}, o.rv2, 1);
    chk({nm, " resp_valid@after"}, o.rv3, 0);
    chk({nm, " req_ready@after"}, o.rdy3, int'(e.bus3 == 4));
  endtask

  initial begin
    vec_t tbl[$];
    vec_t e, rr;
    obs_t o;
    int n, k, q;
    bit quiet;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset req_ready", int'(req_ready), 1);
    chk("reset bus_op", int'(bus_op), 4);
    chk("reset snoop_result", int'(snoop_result), 3);
    chk("reset l1_msg", int'(l1_msg), 4);
    chk("reset resp_valid", int'(resp_valid), 0);
    chk("reset evict_valid", int'(evict_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // op set tag snp | bus1 l1a sr l1 hit way ev etag ed bus3
    tbl.push_back('{0, 1, 'h11, 0, 0, 4, 3, 1, 0, 0, 0, 0, 0, 4});
    tbl.push_back('{0, 1, 'h11, 0, 4, 4, 3, 1, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{0, 0, 'hA0, 0, 0, 4, 3, 1, 0, 0, 0, 0, 0, 4});
    tbl.push_back('{0, 0, 'hA1, 0, 0, 4, 3, 1, 0, 1, 0, 0, 0, 4});
    tbl.push_back('{0, 0, 'hA2, 0, 0, 4, 3, 1, 0, 2, 0, 0, 0, 4});
    tbl.push_back('{0, 0, 'hA3, 0, 0, 4, 3, 1, 0, 3, 0, 0, 0, 4});
    tbl.push_back('{0, 0, 'hA0, 0, 4, 4, 3, 1, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{0, 0, 'hB0, 0, 0, 4, 3, 3, 0, 2, 1, 'hA2, 0, 4});
    tbl.push_back('{1, 0, 'hA1, 0, 4, 4, 3, 4, 1, 1, 0, 0, 0, 4});
    tbl.push_back('{0, 0, 'hA0, 0, 4, 4, 3, 1, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{0, 0, 'hA3, 0, 4, 4, 3, 1, 1, 3, 0, 0, 0, 4});
    tbl.push_back('{0, 0, 'hC0, 0, 1, 4, 3, 3, 0, 1, 1, 'hA1, 1, 0});
    tbl.push_back('{0, 2, 'h22, 1, 0, 4, 3, 1, 0, 0, 0, 0, 0, 4});
    tbl.push_back('{1, 2, 'h22, 0, 2, 4, 3, 4, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{2, 2, 'h22, 0, 1, 0, 2, 4, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{2, 2, 'h22, 0, 4, 4, 1, 4, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{4, 1, 'h11, 0, 4, 4, 1, 2, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{0, 1, 'h11, 0, 0, 4, 3, 1, 0, 0, 0, 0, 0, 4});
    tbl.push_back('{5, 3, 'h33, 0, 4, 4, 0, 4, 0, 0, 0, 0, 0, 4});
    tbl.push_back('{3, 1, 'h11, 0, 4, 4, 0, 4, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{1, 1, 'h11, 0, 4, 4, 3, 4, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{4, 1, 'h11, 0, 1, 0, 2, 2, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{5, 2, 'h22, 0, 4, 4, 1, 2, 1, 0, 0, 0, 0, 4});
    foreach (tbl[i]) begin
      do_req(tbl[i], o);
      model_step(tbl[i], e);
      check_obs($sformatf("vec%0d", i), o, tbl[i]);
    end
    // Clear-all: busy for SETS cycles, then a single completion strobe.
    wait_ready();
    req_valid = 1'b1;
    req_op = 3'd6;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    quiet = 1'b1;
    while (!req_ready && n < 20) begin
      if (resp_valid || bus_op != 3'd4 || l1_msg != 3'd4 || snoop_result != 2'd3 || evict_valid) quiet = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("clear busy cycles", n, 4);
    chk("clear outputs idle", int'(quiet), 1);
    chk("clear done resp_valid", int'(resp_valid), 1);
    @(negedge clk);
    chk("clear resp_valid pulse", int'(resp_valid), 0);
    model_reset();
    rr = '{0, 0, 'hA0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_req(rr, o);
    model_step(rr, e);
    check_obs("after_clear", o, e);
    chk("after_clear resp_hit", o.hit, 0);
    // Reset while in LOOKUP: outputs drop at once and nothing is written.
    wait_ready();
    req_valid = 1'b1;
    req_op = 3'd0;
    req_set = 2'd0;
    req_tag = 8'h06;
    bus_snoop_in = 2'd0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("lookup bus_op before reset", int'(bus_op), 0);
    rst_n = 1'b0;
    #1;
    chk("midreset bus_op", int'(bus_op), 4);
    chk("midreset req_ready", int'(req_ready), 1);
    chk("midreset l1_msg", int'(l1_msg), 4);
    chk("midreset snoop_result", int'(snoop_result), 3);
    chk("midreset resp_valid", int'(resp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    rr.tag = 'h06;
    do_req(rr, o);
    model_step(rr, e);
    check_obs("post_reset", o, e);
    chk("post_reset resp_hit", o.hit, 0);
    chk("post_reset resp_way", o.way, 0);
    for (k = 0; k < 400; k++) begin
      q = $urandom_range(0, 9);
      rr.op = q < 4 ? 0 : q < 7 ? 1 : q == 7 ? 2 : q == 8 ? 4 : ($urandom_range(0, 1) ? 3 : 5);
      rr.set = $urandom_range(0, 3);
      rr.tag = $urandom_range(0, 5);
      rr.snp = $urandom_range(0, 2);
      do_req(rr, o);
      model_step(rr, e);
      check_obs($sformatf("rnd%0d", k), o, e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/llc_set_engine.md
# llc_set_engine

Parametrised N-way, S-set LLC tag/MESI/tree-PLRU engine with a request state machine. It serves local processor reads and writes, handles snooped bus operations, selects and reports victims, and drives bus-operation, snoop-result and L1-message codes using the shared LLC encodings. It sits between the LLC request decoder and the bus/L1 interface logic, and generalises the fixed 16-way definitions to any power-of-two associativity.

## Interface
- WAYS, 16: associativity, power of two, 2..16; PLRU tree holds WAYS-1 bits per set
- SETS, 64: number of sets, power of two
- TAG_BITS, 12: tag width
- SET_BITS, log2(SETS): derived, not overridden
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine idle and accepting
- req_op  in  3  0 local read, 1 local write, 2 snoop READ, 3 snoop WRITE, 4 snoop RWIM, 5 snoop INVALIDATE, 6 clear-all
- req_set  in  SET_BITS  set index
- req_tag  in  TAG_BITS  tag
- bus_snoop_in  in  2  others' snoop result for our bus op (NOHIT=0, HIT=1, HITM=2)
- bus_op  out  3  READ=0, WRITE=1, INVALIDATE=2, RWIM=3, NOBUSOP=4
- snoop_result  out  2  our reply to a snooped op: NOHIT=0, HIT=1, HITM=2, NORESULT=3
- l1_msg  out  3  GETLINE=0, SENDLINE=1, INVALIDATELINE=2, EVICTLINE=3, NOMESSAGE=4
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  tag matched a non-INVALID way
- resp_way  out  log2(WAYS)  hit way or filled way
- evict_valid  out  1  a valid victim was displaced
- evict_tag  out  TAG_BITS  victim tag
- evict_dirty  out  1  victim was MODIFIED

## Operation
- Per way: tag and MESI state (INVALID=0, SHARED=1, EXCLUSIVE=2, MODIFIED=3). Per set: WAYS-1 PLRU bits, node 0 is the root, children of i are 2i+1 and 2i+2.
- PLRU victim selection: walk from the root; bit 0 goes left, bit 1 goes right. An access to way w sets each bit on its path to point away from w. Only local ops update PLRU.
- Miss fill way: the lowest-numbered INVALID way; if no way is INVALID, the PLRU victim.
- Local read hit: no bus op; SENDLINE; state unchanged.
- Local read miss: bus READ; fill with EXCLUSIVE if bus_snoop_in is NOHIT, otherwise SHARED; SENDLINE.
- Local write hit: M or E goes to M with NOBUSOP. S goes to M with bus INVALIDATE. l1_msg is NOMESSAGE.
- Local write miss: bus RWIM; fill MODIFIED; NOMESSAGE.
- Victim displacement on a miss (victim not INVALID): evict_valid=1, evict_tag, evict_dirty=(victim was M), l1_msg=EVICTLINE (this overrides SENDLINE). A dirty victim also drives bus_op=WRITE; the fill bus op follows on the next request cycle, held internally.
- Snoop READ: M gives HITM, bus WRITE, GETLINE, goes to S. E or S gives HIT and goes to S. I gives NOHIT.
- Snoop RWIM: M gives HITM, bus WRITE, GETLINE then INVALIDATELINE, goes to I. E or S gives HIT, INVALIDATELINE, goes to I. I gives NOHIT.
- Snoop INVALIDATE: S gives HIT, INVALIDATELINE, goes to I. Otherwise NOHIT with no change.
- Snoop WRITE: NOHIT, no change.
- Local ops drive snoop_result=NORESULT.
- Clear-all: walks sets 0..SETS-1 at one per cycle, setting all ways INVALID and PLRU bits to 0. No outputs are asserted except resp_valid on completion.

## Timing
- States: IDLE, LOOKUP, UPDATE, EVICT_WB, CLEAR.
- IDLE: req_ready=1. A request is accepted on the edge where req_valid&req_ready. The engine then goes to CLEAR for op 6, otherwise to LOOKUP.
- LOOKUP (cycle 1): arrays read, hit/victim computed, bus_op valid. bus_snoop_in is sampled at the end of this cycle.
- UPDATE (cycle 2): arrays written, resp_valid=1 with all response fields valid for this cycle. Next state is IDLE, or EVICT_WB if a dirty-victim fill is pending.
- EVICT_WB (cycle 3): bus_op = held READ or RWIM. The fill state was already written in UPDATE. Returns to IDLE.
- Latency is accept to resp_valid = 2 cycles; throughput is 1 request per 3 cycles, or 4 with EVICT_WB.
- CLEAR: SETS cycles with req_ready=0, then resp_valid for one cycle, then IDLE.
- Outside their strobe cycles, outputs idle at bus_op=NOBUSOP, snoop_result=NORESULT, l1_msg=NOMESSAGE, and 0 for all others.
- Reset: asynchronous to IDLE. All MESI=INVALID, PLRU=0, tags=0, req_ready=1, all other outputs at their idle values. Reset mid-request drops the request with no partial array write.
- req_* are ignored while req_ready=0.

## Test plan
- WAYS=4, SETS=4, TAG_BITS=8, after reset: local read set 1 tag 0x11 with bus_snoop_in=NOHIT -> cycle 1 bus_op=READ; cycle 2 resp_hit=0, resp_way=0, l1_msg=SENDLINE; the line is E. Repeat the read -> resp_hit=1, bus_op stays NOBUSOP.
- Fill set 0 with tags 0xA0-0xA3 (ways 0-3), then read 0xA0 -> PLRU victim is way 2. Read 0xB0 -> resp_way=2, evict_valid=1, evict_tag=0xA2, evict_dirty=0, EVICTLINE.
- Write 0xA1 (goes to M), then force its eviction -> evict_dirty=1, bus_op=WRITE in cycle 1, bus_op=READ in EVICT_WB, resp_valid on cycle 2 only.
- Read with bus_snoop_in=HIT (S), then local write -> bus_op=INVALIDATE and state M. Snoop READ on the same tag -> snoop_result=HITM, bus WRITE, GETLINE, state S.
- Snoop RWIM on an E line -> HIT, INVALIDATELINE, state I. Snoop INVALIDATE on an absent tag -> NOHIT. Snoop WRITE -> NOHIT, no change.
- Clear-all -> req_ready=0 for exactly 4 cycles, then resp_valid; a subsequent read misses. Assert rst_n in LOOKUP -> outputs return to idle values immediately and no array state changes.
